// File: rtl/riscv_legacy_core.sv
// Single-cycle RV32I-subset core: decoder, register file, ALU and private instruction/data memories.
// One instruction retires per rising clk edge; the decoded control and key datapath nets are exported for observation.
module riscv_legacy_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        reg_we,
  output logic        mem_we,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [1:0]  res_src,
  output logic [1:0]  pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        is_branch, is_jal, is_jalr, a_zero, take;
  logic [31:0] rs1_val, rs2_val, imm_ext, src_a, src_b, wb_data, pc_plus4, pc_next;
  logic signed [31:0] src_a_s;
  logic [32:0] sub_full;
  logic        flag_z, flag_n, flag_c, flag_v;

  function automatic logic [31:0] ext_imm(input logic [31:0] i, input logic [2:0] sel);
    logic [31:0] r;
    case (sel)
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      default: r = {{20{i[31]}}, i[31:20]};
    endcase
    return r;
  endfunction

  // funct7[5] selects SUB only for register-register ops; for shifts it selects arithmetic.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  assign instr  = imem[pc[IA_W+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    imm_src   = IMM_I;
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    res_src   = 2'd0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    a_zero    = 1'b0;
    case (opcode)
      7'b0000011: begin reg_we = 1'b1; alu_src = 1'b1; res_src = 2'd1; end
      7'b0100011: begin mem_we = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
      7'b0010011: begin reg_we = 1'b1; alu_src = 1'b1; alu_ctrl = alu_dec(funct3, instr[30], 1'b0); end
      7'b0110011: begin reg_we = 1'b1; alu_ctrl = alu_dec(funct3, instr[30], 1'b1); end
      7'b1100011: begin is_branch = 1'b1; imm_src = IMM_B; alu_ctrl = ALU_SUB; end
      7'b1101111: begin reg_we = 1'b1; res_src = 2'd2; imm_src = IMM_J; is_jal = 1'b1; end
      7'b1100111: begin reg_we = 1'b1; res_src = 2'd2; alu_src = 1'b1; is_jalr = 1'b1; end
      7'b0110111: begin reg_we = 1'b1; alu_src = 1'b1; imm_src = IMM_U; a_zero = 1'b1; end
      default: ;
    endcase
  end

  assign imm_ext = ext_imm(instr, imm_src);
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign src_a   = a_zero ? 32'd0 : rs1_val;
  assign src_a_s = src_a;
  assign src_b   = alu_src ? imm_ext : rs2_val;

  // C is the carry out of a + ~b + 1, i.e. set when no borrow (a >= b unsigned).
  assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
  assign flag_c   = sub_full[32];
  assign flag_n   = sub_full[31];
  assign flag_z   = (sub_full[31:0] == 32'd0);
  assign flag_v   = (src_a[31] ^ src_b[31]) & (src_a[31] ^ sub_full[31]);

  always_comb begin
    case (alu_ctrl)
      ALU_SUB:  alu_out = sub_full[31:0];
      ALU_AND:  alu_out = src_a & src_b;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_XOR:  alu_out = src_a ^ src_b;
      ALU_SLT:  alu_out = {31'd0, flag_n ^ flag_v};
      ALU_SLTU: alu_out = {31'd0, ~flag_c};
      ALU_SLL:  alu_out = src_a << src_b[4:0];
      ALU_SRL:  alu_out = src_a >> src_b[4:0];
      ALU_SRA:  alu_out = src_a_s >>> src_b[4:0];
      default:  alu_out = src_a + src_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  take = flag_z;
      3'b001:  take = ~flag_z;
      3'b100:  take = flag_n ^ flag_v;
      3'b101:  take = ~(flag_n ^ flag_v);
      3'b110:  take = ~flag_c;
      3'b111:  take = flag_c;
      default: take = 1'b0;
    endcase
    if (is_jal || (is_branch && take)) pc_src = 2'd1;
    else if (is_jalr)                  pc_src = 2'd2;
    else                               pc_src = 2'd0;
  end

  assign pc_plus4    = pc + 32'd4;
  assign mem_rd_data = dmem[alu_out[DA_W+1:2]];
  assign mem_wd_data = rs2_val;

  always_comb begin
    case (res_src)
      2'd1:    wb_data = mem_rd_data;
      2'd2:    wb_data = pc_plus4;
      default: wb_data = alu_out;
    endcase
    case (pc_src)
      2'd1:    pc_next = pc + imm_ext;
      2'd2:    pc_next = {alu_out[31:1], 1'b0};
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else      pc <= pc_next;
  end

  // Storage is never cleared; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && reg_we && (rd != 5'd0)) rf[rd] <= wb_data;
    if (rst && mem_we) dmem[alu_out[DA_W+1:2]] <= rs2_val;
  end

endmodule

// File: tb/tb_riscv_legacy_core.sv
// Directed per-instruction bench for riscv_legacy_core; programs are written into the core's instruction memory.
module tb_riscv_legacy_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we, mem_we, alu_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  res_src, pc_src;
  logic [31:0] instr, alu_out, mem_rd_data, mem_wd_data, pc;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_legacy_core #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .reg_we(reg_we), .mem_we(mem_we), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .res_src(res_src), .pc_src(pc_src),
    .instr(instr), .alu_out(alu_out), .mem_rd_data(mem_rd_data),
    .mem_wd_data(mem_wd_data), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0000_0013;
  endtask

  task automatic begin_prog();
    rst = 1'b0;
    clear_imem();
  endtask

  task automatic release_rst();
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    clear_imem();
    dut.imem[0] = 32'h0040_0213;  // addi x4,x0,4
    dut.imem[1] = 32'hfff0_0293;  // addi x5,x0,-1
    dut.imem[2] = 32'h8000_0337;  // lui  x6,0x80000
    dut.imem[3] = 32'h0020_0393;  // addi x7,x0,2
    #1;
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
    n_cmp++; if (instr !== 32'h0040_0213) begin n_bad++; $display("FAIL reset_fetch got %h want %h", instr, 32'h0040_0213); end
    #6 rst = 1'b1;
    repeat (4) step();
    n_cmp++; if (pc !== 32'd16) begin n_bad++; $display("FAIL preload_pc got %h want %h", pc, 32'd16); end
    n_cmp++; if (dut.rf[5] !== 32'hffff_ffff) begin n_bad++; $display("FAIL preload_x5 got %h want %h", dut.rf[5], 32'hffff_ffff); end
    rst = 1'b0;
    #2;
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL async_reset_pc got %h want %h", pc, 32'd0); end
    dut.imem[0] = 32'h0630_0213;  // addi x4,x0,99 must not retire while reset is held
    step();
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL held_reset_pc got %h want %h", pc, 32'd0); end
    n_cmp++; if (dut.rf[4] !== 32'd4) begin n_bad++; $display("FAIL reset_x4 got %h want %h", dut.rf[4], 32'd4); end
    n_cmp++; if (dut.rf[5] !== 32'hffff_ffff) begin n_bad++; $display("FAIL reset_x5 got %h want %h", dut.rf[5], 32'hffff_ffff); end
    n_cmp++; if (dut.rf[6] !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_x6 got %h want %h", dut.rf[6], 32'h8000_0000); end
    n_cmp++; if (dut.rf[7] !== 32'd2) begin n_bad++; $display("FAIL reset_x7 got %h want %h", dut.rf[7], 32'd2); end
  endtask

  task automatic test_blt();
    logic [31:0] prog [18];
    logic [31:0] exp_pc [8];
    prog = '{32'h02024e63, 32'h02004c63, 32'h00404863, 32'h13, 32'h13, 32'h13,
             32'h02504263, 32'h0002c863, 32'h13, 32'h13, 32'h13, 32'h00024863,
             32'h0002c463, 32'h13, 32'hfc7344e3, 32'h13, 32'h13, 32'h13};
    exp_pc = '{32'd4, 32'd8, 32'd24, 32'd28, 32'd44, 32'd48, 32'd56, 32'd0};
    begin_prog();
    for (int i = 0; i < 18; i++) dut.imem[i] = prog[i];
    release_rst();
    n_cmp++; if (alu_ctrl !== 4'd1) begin n_bad++; $display("FAIL blt_alu_ctrl got %0d want %0d", alu_ctrl, 1); end
    n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL blt_reg_we got %b want %b", reg_we, 1'b0); end
    n_cmp++; if (imm_src !== 3'd2) begin n_bad++; $display("FAIL blt_imm_src got %0d want %0d", imm_src, 2); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_cmp++; if (pc_src !== 2'd1) begin n_bad++; $display("FAIL blt_overflow_pc_src got %0d want %0d", pc_src, 1); end
      end
      step();
      n_cmp++;
      if (pc !== exp_pc[i]) begin n_bad++; $display("FAIL blt_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
    end
  endtask

  task automatic test_unsigned_branches();
    begin_prog();
    dut.imem[0] = 32'h0052_6463;  // bltu x4,x5,+8  (taken)
    dut.imem[2] = 32'h0052_7463;  // bgeu x4,x5,+8  (not taken)
    dut.imem[3] = 32'h0042_0463;  // beq  x4,x4,+8  (taken)
    dut.imem[5] = 32'h0042_1463;  // bne  x4,x4,+8  (not taken)
    release_rst();
    n_cmp++; if (pc_src !== 2'd1) begin n_bad++; $display("FAIL bltu_pc_src got %0d want %0d", pc_src, 1); end
    step();
    n_cmp++; if (pc !== 32'd8) begin n_bad++; $display("FAIL bltu_pc got %h want %h", pc, 32'd8); end
    n_cmp++; if (pc_src !== 2'd0) begin n_bad++; $display("FAIL bgeu_pc_src got %0d want %0d", pc_src, 0); end
    step();
    n_cmp++; if (pc !== 32'd12) begin n_bad++; $display("FAIL bgeu_pc got %h want %h", pc, 32'd12); end
    step();
    n_cmp++; if (pc !== 32'd20) begin n_bad++; $display("FAIL beq_pc got %h want %h", pc, 32'd20); end
    step();
    n_cmp++; if (pc !== 32'd24) begin n_bad++; $display("FAIL bne_pc got %h want %h", pc, 32'd24); end
  endtask

  task automatic test_load_store();
    begin_prog();
    dut.imem[0] = 32'h0040_2023;  // sw x4,0(x0)
    dut.imem[1] = 32'h0000_2403;  // lw x8,0(x0)
    release_rst();
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sw_mem_we got %b want %b", mem_we, 1'b1); end
    n_cmp++; if (mem_wd_data !== 32'd4) begin n_bad++; $display("FAIL sw_wd_data got %h want %h", mem_wd_data, 32'd4); end
    n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL sw_reg_we got %b want %b", reg_we, 1'b0); end
    n_cmp++; if (imm_src !== 3'd1) begin n_bad++; $display("FAIL sw_imm_src got %0d want %0d", imm_src, 1); end
    step();
    n_cmp++; if (res_src !== 2'd1) begin n_bad++; $display("FAIL lw_res_src got %0d want %0d", res_src, 1); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL lw_mem_we got %b want %b", mem_we, 1'b0); end
    n_cmp++; if (mem_rd_data !== 32'd4) begin n_bad++; $display("FAIL lw_rd_data got %h want %h", mem_rd_data, 32'd4); end
    step();
    n_cmp++; if (dut.rf[8] !== 32'd4) begin n_bad++; $display("FAIL lw_x8 got %h want %h", dut.rf[8], 32'd4); end
  endtask

  task automatic test_jumps();
    begin_prog();
    dut.imem[0] = 32'h00c0_00ef;  // jal  x1,+12
    dut.imem[1] = 32'h0050_0013;  // addi x0,x0,5
    dut.imem[2] = 32'h0000_0593;  // addi x11,x0,0
    dut.imem[3] = 32'h0000_8067;  // jalr x0,0(x1)
    release_rst();
    n_cmp++; if (res_src !== 2'd2) begin n_bad++; $display("FAIL jal_res_src got %0d want %0d", res_src, 2); end
    n_cmp++; if (pc_src !== 2'd1) begin n_bad++; $display("FAIL jal_pc_src got %0d want %0d", pc_src, 1); end
    step();
    n_cmp++; if (pc !== 32'd12) begin n_bad++; $display("FAIL jal_pc got %h want %h", pc, 32'd12); end
    n_cmp++; if (dut.rf[1] !== 32'd4) begin n_bad++; $display("FAIL jal_x1 got %h want %h", dut.rf[1], 32'd4); end
    n_cmp++; if (pc_src !== 2'd2) begin n_bad++; $display("FAIL jalr_pc_src got %0d want %0d", pc_src, 2); end
    step();
    n_cmp++; if (pc !== 32'd4) begin n_bad++; $display("FAIL jalr_pc got %h want %h", pc, 32'd4); end
    step();
    n_cmp++; if (alu_out !== 32'd0) begin n_bad++; $display("FAIL x0_write got %h want %h", alu_out, 32'd0); end
  endtask

  task automatic test_alu();
    logic [31:0] prog [6];
    logic [31:0] exp_res [6];
    prog    = '{32'h0073_0633, 32'h4073_06b3, 32'h0073_2733, 32'h4073_57b3, 32'h4043_5813, 32'hfff3_b893};
    exp_res = '{32'h8000_0002, 32'h7fff_fffe, 32'h0000_0001, 32'he000_0000, 32'hf800_0000, 32'h0000_0001};
    begin_prog();
    for (int i = 0; i < 6; i++) dut.imem[i] = prog[i];
    release_rst();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (alu_out !== exp_res[i]) begin n_bad++; $display("FAIL alu[%0d] got %h want %h", i, alu_out, exp_res[i]); end
      step();
    end
    n_cmp++; if (dut.rf[15] !== 32'he000_0000) begin n_bad++; $display("FAIL sra_x15 got %h want %h", dut.rf[15], 32'he000_0000); end
    n_cmp++; if (dut.rf[13] !== 32'h7fff_fffe) begin n_bad++; $display("FAIL sub_x13 got %h want %h", dut.rf[13], 32'h7fff_fffe); end
  endtask

  task automatic test_unknown_opcode();
    begin_prog();
    dut.imem[0] = 32'hffff_ffff;
    release_rst();
    n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL unk_reg_we got %b want %b", reg_we, 1'b0); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL unk_mem_we got %b want %b", mem_we, 1'b0); end
    n_cmp++; if (pc_src !== 2'd0) begin n_bad++; $display("FAIL unk_pc_src got %0d want %0d", pc_src, 0); end
    step();
    n_cmp++; if (pc !== 32'd4) begin n_bad++; $display("FAIL unk_pc got %h want %h", pc, 32'd4); end
  endtask

  initial begin
    test_reset();
    test_blt();
    test_unsigned_branches();
    test_load_store();
    test_jumps();
    test_alu();
    test_unknown_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
